// File: rtl/seq_sub_nbit.sv
// seq_sub_nbit -- multi-cycle N-bit subtractor, D = a - b - bin.
//
// One W-bit slice of the difference is produced per clock, LSB slice first.
// The borrow between slices is carried in a register. Latency is N/W RUN
// cycles plus one DONE cycle, so this trades speed for a narrow datapath.
//
// Parameters:
//   N  operand/result width (N % W must be 0)
//   W  slice width per clock (1 <= W <= N)
//
// Ports:
//   clk    clock, rising edge
//   rst    synchronous active-high reset
//   start  request, sampled only in IDLE
//   a, b   minuend / subtrahend, captured on accepted start
//   bin    borrow-in, captured on accepted start
//   busy   high while RUN
//   done   one-cycle pulse, D/bout valid
//   D      difference (meaningful from done until the next accepted start)
//   bout   borrow out of the MSB slice (unsigned a < b + bin)
//   ovf    signed overflow, only when SEQ_SUB_OVF_EN is defined
//
// Optional feature macro: SEQ_SUB_OVF_EN (adds the ovf port and its logic).

module seq_sub_nbit #(
  parameter int N = 32,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] D,
  output logic         bout
`ifdef SEQ_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int S  = N / W;
  localparam int CW = (S > 1) ? $clog2(S) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [N-1:0]   a_r, b_r;
  logic           brw;
  logic [CW-1:0]  cnt;

  logic [W-1:0]   a_sl, b_sl;
  logic [W:0]     diff;
  logic           last;

  // Select the current slice of each operand. Written as a compare-per-slice
  // mux so the slice index never needs a width-mismatched multiply.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int k = 0; k < S; k++) begin
      if (cnt == CW'(k)) begin
        a_sl = a_r[k*W +: W];
        b_sl = b_r[k*W +: W];
      end
    end
  end

  // (W+1)-bit subtract; the extra MSB comes out as the borrow for the next slice.
  assign diff = {1'b0, a_sl} - {1'b0, b_sl} - {{W{1'b0}}, brw};
  assign last = (cnt == CW'(S - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      brw   <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      D     <= '0;
      bout  <= 1'b0;
`ifdef SEQ_SUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            brw   <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          // Upper slices of D keep stale data until their turn comes.
          for (int k = 0; k < S; k++) begin
            if (cnt == CW'(k)) D[k*W +: W] <= diff[W-1:0];
          end
          brw <= diff[W];
          if (last) begin
            bout  <= diff[W];
`ifdef SEQ_SUB_OVF_EN
            // diff[W-1] is the final MSB of D being written this same edge.
            ovf   <= (a_r[N-1] != b_r[N-1]) && (diff[W-1] != a_r[N-1]);
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // start is ignored here; a new request is only taken from IDLE.
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
